// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the byte-sequencer FSM states.
// Used by the ALU, the UART sequencer (alu_uart_if) and its testbench.
package alu_pkg;

    localparam int OPW = 6;

    localparam logic [OPW-1:0] ADD = 6'b100000;
    localparam logic [OPW-1:0] SUB = 6'b100010;
    localparam logic [OPW-1:0] AND = 6'b100100;
    localparam logic [OPW-1:0] OR  = 6'b100101;
    localparam logic [OPW-1:0] XOR = 6'b100110;
    localparam logic [OPW-1:0] SRA = 6'b000011;
    localparam logic [OPW-1:0] SRL = 6'b000010;
    localparam logic [OPW-1:0] NOR = 6'b100111;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

endpackage

// File: rtl/alu_if_timeout.sv
// Inter-byte idle counter for alu_uart_if. Counts enabled cycles since the
// last clear and flags expiry on the CYCLES-th idle cycle. Only instantiated
// when ALU_IF_TIMEOUT_EN is defined.
module alu_if_timeout #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == W'(CYCLES - 1));

    // Count idle enabled cycles; saturate at the expiry value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_if.sv
// Byte-stream sequencer between the UART rx/tx pair and the ALU.
// Collects A, B and opcode bytes, holds them on the ALU inputs, then sends
// the ALU result back through a start/done transmitter handshake.
// Optional feature: define ALU_IF_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES idle cycles in WAIT_B / WAIT_OP.
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int LEN_DATO       = 8,
    parameter int LEN_OP         = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [LEN_DATO-1:0] i_rx_data,
    input  logic                i_rx_done,
    output logic [LEN_DATO-1:0] o_dato_a,
    output logic [LEN_DATO-1:0] o_dato_b,
    output logic [LEN_OP-1:0]   o_op_code,
    input  logic [LEN_DATO-1:0] i_resultado,
    output logic [LEN_DATO-1:0] o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_done,
    output logic                o_busy
);

    state_t state;
    logic   to_expired;

`ifdef ALU_IF_TIMEOUT_EN
    logic to_enable;
    logic to_clear;

    // Counter only runs mid-frame; any accepted byte or leaving those states
    // restarts it, so entry into WAIT_B / WAIT_OP always starts from zero.
    assign to_enable = (state == WAIT_B) || (state == WAIT_OP);
    assign to_clear  = i_rx_done || !to_enable;

    alu_if_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (i_clock),
        .reset   (i_reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    assign o_busy = (state != WAIT_A);

    // Frame sequencer: byte capture, result latch and one-cycle tx start.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= WAIT_A;
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_op_code  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // An arriving byte beats an expiring timeout.
                    if (i_rx_done) begin
                        o_dato_b <= i_rx_data;
                        state    <= WAIT_OP;
                    end else if (to_expired) begin
                        state <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op_code <= i_rx_data[LEN_OP-1:0];
                        state     <= SEND;
                    end else if (to_expired) begin
                        state <= WAIT_A;
                    end
                end
                SEND: begin
                    // Operands have been stable since the opcode edge, so the
                    // combinational ALU result is settled here.
                    o_tx_data  <= i_resultado;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed testbench for alu_uart_if with a behavioural ALU and a result
// scoreboard checked at every o_tx_start pulse.
module tb_alu_uart_if;
    import alu_pkg::*;

    localparam int LD = 8;
    localparam int LO = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LD-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic [LD-1:0] dato_a, dato_b, resultado, tx_data;
    logic [LO-1:0] op_code;
    logic          tx_start, tx_done = 1'b0, busy;

    int tests = 0;
    int fails = 0;
    logic [LD-1:0] exp_q[$];
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    alu_uart_if #(.LEN_DATO(LD), .LEN_OP(LO), .TIMEOUT_CYCLES(16)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .o_dato_a    (dato_a),
        .o_dato_b    (dato_b),
        .o_op_code   (op_code),
        .i_resultado (resultado),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_done   (tx_done),
        .o_busy      (busy)
    );

    // Behavioural ALU: default passes A through.
    always_comb begin
        case (op_code)
            ADD:     resultado = dato_a + dato_b;
            SUB:     resultado = dato_a - dato_b;
            AND:     resultado = dato_a & dato_b;
            OR:      resultado = dato_a | dato_b;
            XOR:     resultado = dato_a ^ dato_b;
            NOR:     resultado = ~(dato_a | dato_b);
            SRA:     resultado = LD'($signed(dato_a) >>> dato_b);
            SRL:     resultado = dato_a >> dato_b;
            default: resultado = dato_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every start pulse pops one expected result; start must never
    // be high two cycles running.
    always @(negedge clk) begin
        if (tx_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            check("start_single", 32'(prev_start), 32'd0);
        end
        prev_start = tx_start;
    end

    task automatic rx_byte(input logic [LD-1:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic frame(input logic [LD-1:0] a, input logic [LD-1:0] b,
                         input logic [LD-1:0] op, input logic [LD-1:0] res,
                         input logic drop);
        int n;
        exp_q.push_back(res);
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
        check("op_code", 32'(op_code), 32'(op[LO-1:0]));
        check("busy_send", 32'(busy), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 8);
        check("start_latency", n, 2);
        if (drop) rx_byte(8'h77);
        tx_ack();
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_a",     32'(dato_a),   32'd0);
        check("rst_b",     32'(dato_b),   32'd0);
        check("rst_op",    32'(op_code),  32'd0);
        check("rst_tx",    32'(tx_data),  32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);

        frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
        frame(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
        frame(8'hF0, 8'h02, 8'h03, 8'hFC, 1'b0);
        frame(8'hF0, 8'h02, 8'h02, 8'h3C, 1'b0);
        frame(8'h12, 8'h34, 8'h26, 8'h26, 1'b1);
        frame(8'h01, 8'h01, 8'h24, 8'h01, 1'b0);
        // Upper opcode bits ignored; undefined opcode passes A through.
        frame(8'h0A, 8'h0B, 8'hE0, 8'h15, 1'b0);
        frame(8'h5A, 8'h0B, 8'h3F, 8'h5A, 1'b0);

        // tx_done outside WAIT_TX is ignored.
        rx_byte(8'h44);
        tx_ack();
        check("txdone_ignored", 32'(busy), 32'd1);
        rx_byte(8'h11);
        rx_byte(8'h27);
        exp_q.push_back(8'hAA);
        @(negedge clk);
        @(negedge clk);
        tx_ack();
        check("busy_nor", 32'(busy), 32'd0);

        // Reset mid-frame.
        rx_byte(8'h10);
        rx_byte(8'h20);
        check("mid_b", 32'(dato_b), 32'h20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_a",    32'(dato_a),  32'd0);
        check("mrst_b",    32'(dato_b),  32'd0);
        check("mrst_op",   32'(op_code), 32'd0);
        check("mrst_tx",   32'(tx_data), 32'd0);
        check("mrst_busy", 32'(busy),    32'd0);
        frame(8'h06, 8'h07, 8'h20, 8'h0D, 1'b0);

        // Idle mid-frame.
        rx_byte(8'h09);
        repeat (15) begin @(posedge clk); #1; end
        check("idle15_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
`ifdef ALU_IF_TIMEOUT_EN
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_keep_a", 32'(dato_a), 32'h09);
`else
        check("no_timeout_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        frame(8'h02, 8'h03, 8'h25, 8'h03, 1'b0);

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
